// File: rtl/pool2d_stream_pkg.sv
// pool_pkg: shared constants and elaboration-time helpers for the
// pool2d_stream slice.
//   MODE_MAX / MODE_AVG : encodings of the 'mode' input.
//   clog2()             : ceiling log2 for sizing counters and indices.
//   lb_depth()          : number of line-buffer entries for a frame width,
//                         i.e. one entry per horizontal window (IMG_W/2).
package pool_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 32'sd0;
    v = value - 32'sd1;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

  function automatic int lb_depth(input int img_w);
    return img_w / 32'sd2;
  endfunction

endpackage

// File: rtl/pool2d_stream_if.sv
// pool2d_stream_if: pixel stream bundle between a producer and pool2d_stream.
//   data_in/valid_in               : input beat, all lanes packed.
//   data_out/valid_out/frame_done  : output beat and end-of-frame pulse.
//   slave  : the pooling block (consumes data_in, drives the outputs).
//   master : the producer/consumer side around it.
interface pool2d_stream_if #(
  parameter int W = 8
);
  logic [W-1:0] data_in;
  logic         valid_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         frame_done;

  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output valid_out,
    output frame_done
  );

  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  valid_out,
    input  frame_done
  );
endinterface

// File: rtl/pool2d_stream_op2.sv
// pool_op2: combinational two-operand reduction for one lane.
//   a, b      : operands, already widened to W = DWIDTH+2 bits.
//   mode      : MODE_MAX selects the larger operand, MODE_AVG the sum.
//   is_signed : 1 compares as two's complement, 0 as unsigned.
//   y         : max(a,b) or a+b (the sum cannot overflow W for <= 4 samples).
module pool_op2
  import pool_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  input  logic         is_signed,
  output logic [W-1:0] y
);

  logic a_gt_s;

  // Compare and select the reduction result
  always_comb begin
    a_gt_s = 1'b0;
    y      = b;
    if (is_signed) begin
      a_gt_s = ($signed(a) > $signed(b));
    end else begin
      a_gt_s = (a > b);
    end
    if (mode == MODE_AVG) begin
      y = a + b;
    end else if (a_gt_s) begin
      y = a;
    end else begin
      y = b;
    end
  end

endmodule

// File: rtl/pool2d_stream.sv
// pool2d_stream: 2x2 / stride-2 streaming pooling over a raster pixel stream
// with CH packed lanes, or a 1-cycle bypass register when pooling is off.
//   clk, reset : clock and synchronous active-high reset.
//   en_pool    : 1 = pool, 0 = bypass; captured at the first beat of a frame.
//   mode       : MODE_MAX / MODE_AVG; captured at the first beat of a frame.
//   bus        : slave side of pool2d_stream_if (data_in/valid_in in,
//                data_out/valid_out/frame_done out, all outputs registered).
// Even rows fold each horizontal pair into the line buffer; odd rows fold
// their pair and combine it with the stored entry to emit one window.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_pool,
  input  logic            mode,
  pool2d_stream_if.slave  bus
);

  localparam int EW       = DWIDTH + 32'sd2;
  localparam int DW       = CH * DWIDTH;
  localparam int LB_DEPTH = lb_depth(IMG_W);
  localparam int CW       = (clog2(IMG_W) < 32'sd1) ? 32'sd1 : clog2(IMG_W);
  localparam int RW       = (clog2(IMG_H) < 32'sd1) ? 32'sd1 : clog2(IMG_H);
  localparam int LBW      = (clog2(LB_DEPTH) < 32'sd1) ? 32'sd1 : clog2(LB_DEPTH);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 32'sd1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 32'sd1);
  // Last column/row that closes a full window; odd trailing ones are dropped.
  localparam logic [CW-1:0] WCOL_LAST = CW'(32'sd2 * (IMG_W / 32'sd2) - 32'sd1);
  localparam logic [RW-1:0] WROW_LAST = RW'(32'sd2 * (IMG_H / 32'sd2) - 32'sd1);
  localparam logic          IS_SIGNED = (SIGNED != 32'sd0) ? 1'b1 : 1'b0;

  logic [CW-1:0]    col_r;
  logic [RW-1:0]    row_r;
  logic             en_r;
  logic             mode_r;
  logic [CH*EW-1:0] pair_r;
  logic [CH*EW-1:0] line_buf_r [LB_DEPTH];
  logic [DW-1:0]    data_out_r;
  logic             valid_out_r;
  logic             frame_done_r;

  logic             start_s;
  logic             en_s;
  logic             mode_s;
  logic             last_pix_s;
  logic             last_win_s;
  logic [LBW-1:0]   lb_idx_s;
  logic [CH*EW-1:0] lb_rd_s;
  logic [CH*EW-1:0] pix_ext_s;
  logic [CH*EW-1:0] h_res_s;
  logic [CH*EW-1:0] v_res_s;
  logic [DW-1:0]    pooled_s;

  // Frame-start detect, effective frame settings and position decode
  always_comb begin
    start_s    = bus.valid_in && (col_r == {CW{1'b0}}) && (row_r == {RW{1'b0}});
    // The first beat of a frame already obeys the settings being captured.
    en_s       = start_s ? en_pool : en_r;
    mode_s     = start_s ? mode : mode_r;
    lb_idx_s   = LBW'(col_r >> 1);
    lb_rd_s    = line_buf_r[lb_idx_s];
    last_pix_s = (col_r == COL_LAST) && (row_r == ROW_LAST);
    last_win_s = (col_r == WCOL_LAST) && (row_r == WROW_LAST);
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic [DWIDTH-1:0] px_s;
    assign px_s = bus.data_in[c*DWIDTH +: DWIDTH];

    if (SIGNED != 0) begin : g_sext
      assign pix_ext_s[c*EW +: EW] = {{2{px_s[DWIDTH-1]}}, px_s};
    end else begin : g_zext
      assign pix_ext_s[c*EW +: EW] = {2'b00, px_s};
    end

    // Horizontal stage: pair register against the current pixel.
    pool_op2 #(.W(EW)) u_h (
      .a         (pair_r[c*EW +: EW]),
      .b         (pix_ext_s[c*EW +: EW]),
      .mode      (mode_s),
      .is_signed (IS_SIGNED),
      .y         (h_res_s[c*EW +: EW])
    );

    // Vertical stage: stored even-row result against the odd-row pair.
    pool_op2 #(.W(EW)) u_v (
      .a         (lb_rd_s[c*EW +: EW]),
      .b         (h_res_s[c*EW +: EW]),
      .mode      (mode_s),
      .is_signed (IS_SIGNED),
      .y         (v_res_s[c*EW +: EW])
    );

    // Average is the 4-sample sum floored by 4: dropping the two LSBs of
    // the DWIDTH+2 sum is the same for arithmetic and logical shifts.
    assign pooled_s[c*DWIDTH +: DWIDTH] = (mode_s == MODE_AVG) ?
                                          v_res_s[c*EW + 2 +: DWIDTH] :
                                          v_res_s[c*EW +: DWIDTH];
  end

  // Raster position counters, advancing on accepted beats only
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (bus.valid_in) begin
      if (col_r == COL_LAST) begin
        col_r <= {CW{1'b0}};
        if (row_r == ROW_LAST) begin
          row_r <= {RW{1'b0}};
        end else begin
          row_r <= row_r + RW'(1'b1);
        end
      end else begin
        col_r <= col_r + CW'(1'b1);
      end
    end
  end

  // Per-frame capture of pooling enable and mode
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r   <= 1'b0;
      mode_r <= 1'b0;
    end else if (start_s) begin
      en_r   <= en_pool;
      mode_r <= mode;
    end
  end

  // Pair register: holds the even-column sample of the current window row
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_r <= {(CH*EW){1'b0}};
    end else if (bus.valid_in && en_s && !col_r[0]) begin
      pair_r <= pix_ext_s;
    end
  end

  // Line buffer: even-row horizontal results, read back on the odd row
  always_ff @(posedge clk) begin
    if (bus.valid_in && en_s && !row_r[0] && col_r[0]) begin
      line_buf_r[lb_idx_s] <= h_res_s;
    end
  end

  // Output register: bypass echo or completed window
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r   <= {DW{1'b0}};
      valid_out_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      valid_out_r  <= 1'b0;
      frame_done_r <= 1'b0;
      if (bus.valid_in) begin
        if (!en_s) begin
          data_out_r   <= bus.data_in;
          valid_out_r  <= 1'b1;
          frame_done_r <= last_pix_s;
        end else if (row_r[0] && col_r[0]) begin
          data_out_r   <= pooled_s;
          valid_out_r  <= 1'b1;
          frame_done_r <= last_win_s;
        end
      end
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.valid_out  = valid_out_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream: directed self-checking bench for pool2d_stream.
// Three instances: A (4x4, 1 lane, unsigned), B (2x2, 2 lanes, signed) and
// C (5x5, 1 lane, unsigned). Only the selected instance sees valid_in.
module tb_pool2d_stream;

  typedef struct packed {
    logic [15:0] d;
    logic        done;
    int          cyc;
  } obs_t;

  logic        clk;
  logic        reset;
  logic        en;
  logic        mode;
  logic [15:0] din;
  logic        vin;
  int          sel;
  int          cyc = 0;
  int          last_cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [15:0] stim_q[$];
  logic [15:0] exp_d[$];
  logic        exp_f[$];
  obs_t        qa[$];
  obs_t        qb[$];
  obs_t        qc[$];

  pool2d_stream_if #(.W(8))  bus_a ();
  pool2d_stream_if #(.W(16)) bus_b ();
  pool2d_stream_if #(.W(8))  bus_c ();

  assign bus_a.data_in  = din[7:0];
  assign bus_a.valid_in = vin && (sel == 0);
  assign bus_b.data_in  = din;
  assign bus_b.valid_in = vin && (sel == 1);
  assign bus_c.data_in  = din[7:0];
  assign bus_c.valid_in = vin && (sel == 2);

  pool2d_stream #(.DWIDTH(8), .CH(1), .IMG_W(4), .IMG_H(4), .SIGNED(0)) u_a (
    .clk(clk), .reset(reset), .en_pool(en), .mode(mode), .bus(bus_a));
  pool2d_stream #(.DWIDTH(8), .CH(2), .IMG_W(2), .IMG_H(2), .SIGNED(1)) u_b (
    .clk(clk), .reset(reset), .en_pool(en), .mode(mode), .bus(bus_b));
  pool2d_stream #(.DWIDTH(8), .CH(1), .IMG_W(5), .IMG_H(5), .SIGNED(0)) u_c (
    .clk(clk), .reset(reset), .en_pool(en), .mode(mode), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk_obs(input logic [15:0] d, input logic f);
    obs_t o;
    o.d    = d;
    o.done = f;
    o.cyc  = cyc;
    return o;
  endfunction

  // Output monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (bus_a.valid_out) qa.push_back(mk_obs({8'h00, bus_a.data_out}, bus_a.frame_done));
    if (bus_b.valid_out) qb.push_back(mk_obs(bus_b.data_out, bus_b.frame_done));
    if (bus_c.valid_out) qc.push_back(mk_obs({8'h00, bus_c.data_out}, bus_c.frame_done));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_seq(input int n, input int first);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(16'(first + i));
  endtask

  task automatic add_exp(input logic [15:0] d, input logic f);
    exp_d.push_back(d);
    exp_f.push_back(f);
  endtask

  // Present the first n beats of stim_q; from beat tog on, en/mode are inverted
  task automatic drive(input int n, input bit gaps, input bit en0, input bit mode0, input int tog);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      din  = stim_q[i];
      vin  = 1'b1;
      en   = (tog >= 0 && i >= tog) ? ~en0 : en0;
      mode = (tog >= 0 && i >= tog) ? ~mode0 : mode0;
      last_cyc = cyc;
      if (gaps) begin
        @(posedge clk);
        #1;
        vin = 1'b0;
        din = 16'hDEAD;
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    vin = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp_outs(input string tag, input int which, input bit chk_lat);
    obs_t got[$];
    case (which)
      0: begin got = qa; qa.delete(); end
      1: begin got = qb; qb.delete(); end
      default: begin got = qc; qc.delete(); end
    endcase
    check_eq({tag, ".count"}, got.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < got.size()) begin
        check_eq($sformatf("%s.data%0d", tag, i), got[i].d, exp_d[i]);
        check_eq($sformatf("%s.done%0d", tag, i), got[i].done, exp_f[i]);
      end
    end
    if (chk_lat && got.size() > 0)
      check_eq({tag, ".latency"}, got[got.size()-1].cyc, last_cyc + 1);
    exp_d.delete();
    exp_f.delete();
  endtask

  initial begin
    reset = 1'b1;
    vin   = 1'b0;
    din   = 16'h0000;
    en    = 1'b0;
    mode  = 1'b0;
    sel   = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst.data_out", bus_a.data_out, 8'h00);
    check_eq("rst.valid_out", bus_a.valid_out, 1'b0);
    check_eq("rst.frame_done", bus_a.frame_done, 1'b0);
    check_eq("rst.data_out_b", bus_b.data_out, 16'h0000);

    // A: max frame then avg frame, back to back
    sel = 0;
    fill_seq(16, 1);
    drive(16, 1'b0, 1'b1, 1'b0, -1);
    drive(16, 1'b0, 1'b1, 1'b1, -1);
    idle(3);
    add_exp(16'd6, 1'b0);  add_exp(16'd8, 1'b0);
    add_exp(16'd14, 1'b0); add_exp(16'd16, 1'b1);
    add_exp(16'd3, 1'b0);  add_exp(16'd5, 1'b0);
    add_exp(16'd11, 1'b0); add_exp(16'd13, 1'b1);
    cmp_outs("max_avg", 0, 1'b1);

    // A: bypass with en/mode flipped mid-frame, then max with them flipped mid-frame
    drive(16, 1'b0, 1'b0, 1'b0, 5);
    drive(16, 1'b0, 1'b1, 1'b0, 3);
    idle(3);
    for (int i = 1; i <= 16; i++) add_exp(16'(i), (i == 16));
    add_exp(16'd6, 1'b0);  add_exp(16'd8, 1'b0);
    add_exp(16'd14, 1'b0); add_exp(16'd16, 1'b1);
    cmp_outs("bypass_then_max", 0, 1'b1);

    // A: max with an idle cycle after every beat
    drive(16, 1'b1, 1'b1, 1'b0, -1);
    idle(3);
    add_exp(16'd6, 1'b0);  add_exp(16'd8, 1'b0);
    add_exp(16'd14, 1'b0); add_exp(16'd16, 1'b1);
    cmp_outs("gaps", 0, 1'b0);

    // A: reset after pixel 7, then a fresh frame
    drive(7, 1'b0, 1'b1, 1'b0, -1);
    @(posedge clk);
    #1;
    vin   = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("midrst.data_out", bus_a.data_out, 8'h00);
    check_eq("midrst.valid_out", bus_a.valid_out, 1'b0);
    qa.delete();
    drive(16, 1'b0, 1'b1, 1'b0, -1);
    idle(3);
    add_exp(16'd6, 1'b0);  add_exp(16'd8, 1'b0);
    add_exp(16'd14, 1'b0); add_exp(16'd16, 1'b1);
    cmp_outs("after_reset", 0, 1'b1);

    // B: signed two-lane 2x2, max then avg
    sel = 1;
    stim_q = '{16'h7FFF, 16'h7FFE, 16'h7FFB, 16'h7FFA};
    drive(4, 1'b0, 1'b1, 1'b0, -1);
    drive(4, 1'b0, 1'b1, 1'b1, -1);
    idle(3);
    add_exp(16'h7FFF, 1'b1);
    add_exp(16'h7FFC, 1'b1);
    cmp_outs("signed2ch", 1, 1'b1);

    // C: 5x5 odd frame, max then avg, back to back
    sel = 2;
    fill_seq(25, 1);
    drive(25, 1'b0, 1'b1, 1'b0, -1);
    drive(25, 1'b0, 1'b1, 1'b1, -1);
    idle(3);
    add_exp(16'd7, 1'b0);  add_exp(16'd9, 1'b0);
    add_exp(16'd17, 1'b0); add_exp(16'd19, 1'b1);
    add_exp(16'd4, 1'b0);  add_exp(16'd6, 1'b0);
    add_exp(16'd14, 1'b0); add_exp(16'd16, 1'b1);
    cmp_outs("odd5x5", 2, 1'b0);

    // Idle instances must not have produced anything stray
    check_eq("stray_a", qa.size(), 0);
    check_eq("stray_b", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
